uart_tx_arbiter: RTL

Round-robin arbiter and byte sequencer that shares one UartTx transmitter among several result producers, such as init/compute blocks dumping return values and cycle counts. It accepts one multi-byte word from the winning requester, then serialises it least-significant byte first through the UartTx WE/READY handshake. It sits between the producer blocks and the single UartTx instance, replacing hand-written per-byte dump states.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter slice.
//   arb_state_t       - sequencer states IDLE / ISSUE / WAIT
//   UART_ARB_HDR_TAG  - high nibble of the optional per-word header byte
//   UART_ARB_MAX_BYTES- largest supported word size in bytes
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic [3:0]  UART_ARB_HDR_TAG   = 4'hA;
  localparam int unsigned UART_ARB_MAX_BYTES = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer-side request bus plus the UartTx byte handshake.
//   req_valid/req_data          - per-requester pending flag and flattened words
//   req_accept/req_done         - per-requester capture / completion pulses
//   busy/grant_id               - sequencer status and current/last winner
//   TX_DATA/TX_WE/TX_READY      - byte handshake toward the single UartTx
// Modports: master = arbiter side, slave = producers/UART/bench side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REQ_BYTES = 8,
  parameter int unsigned W_ID      = 2
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*8*REQ_BYTES-1:0] req_data;
  logic [NUM_REQ-1:0]             req_accept;
  logic [NUM_REQ-1:0]             req_done;
  logic                           busy;
  logic [W_ID-1:0]                grant_id;
  logic [7:0]                     TX_DATA;
  logic                           TX_WE;
  logic                           TX_READY;

  modport master (
    input  req_valid, req_data, TX_READY,
    output req_accept, req_done, busy, grant_id, TX_DATA, TX_WE
  );

  modport slave (
    output req_valid, req_data, TX_READY,
    input  req_accept, req_done, busy, grant_id, TX_DATA, TX_WE
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search.
//   req - request vector
//   ptr - last granted index; search starts at ptr+1 and wraps modulo NUM_REQ
//   win - first asserted index in that order (ptr when nothing is requested)
//   any - at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W_ID    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [W_ID-1:0]    ptr,
  output logic [W_ID-1:0]    win,
  output logic               any
);

  always_comb begin
    int unsigned        idx;
    logic [NUM_REQ-1:0] sh;
    win = ptr;
    any = 1'b0;
    idx = 0;
    sh  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sh  = req >> idx;
      if (!any && sh[0]) begin
        any = 1'b1;
        win = W_ID'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UartTx among NUM_REQ word producers.
// Accepts one REQ_BYTES word from the round-robin winner and sends it
// least-significant byte first through the TX_WE / TX_READY handshake.
//   CLK, RST - clock, synchronous active-high reset
//   bus      - uart_tx_arbiter_if.master (requests, status, UART byte port)
// Build option: UART_TX_ARB_HEADER_EN prefixes each word with 8'hA0 | grant_id.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REQ_BYTES = 8,
  parameter int unsigned W_ID      = 2
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_arbiter_if.master bus
);

`ifdef UART_TX_ARB_HEADER_EN
  localparam int unsigned HDR_BYTES = 1;
`else
  localparam int unsigned HDR_BYTES = 0;
`endif

  localparam int unsigned WORD_W = 8 * REQ_BYTES;
  localparam int unsigned CNT_W  = $clog2(UART_ARB_MAX_BYTES + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REQ_BYTES + HDR_BYTES - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t         state;
  logic [WORD_W-1:0]  shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] accept_q;
  logic [NUM_REQ-1:0] done_q;
  logic               busy_q;
  logic [W_ID-1:0]    grant_q;
  logic [7:0]         tx_data_q;
  logic               tx_we_q;

  logic [W_ID-1:0]    win;
  logic               any;
  logic               hdr_slot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .W_ID    (W_ID)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (grant_q),
    .win (win),
    .any (any)
  );

  // Byte slot 0 carries the header when the option is built in.
  assign hdr_slot = (HDR_BYTES != 0) && (cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      accept_q  <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      grant_q   <= W_ID'(NUM_REQ - 1);
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
    end else begin
      accept_q <= '0;
      done_q   <= '0;
      tx_we_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            grant_q  <= win;
            shift_q  <= WORD_W'(bus.req_data >> (int'(win) * WORD_W));
            accept_q <= ONE << win;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.TX_READY) begin
            tx_data_q <= hdr_slot ? {UART_ARB_HDR_TAG, 4'(grant_q)} : shift_q[7:0];
            tx_we_q   <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // READY falling is the UART's acknowledgement of the byte.
          if (!bus.TX_READY) begin
            if (cnt_q == LAST) begin
              done_q <= ONE << grant_q;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              if (!hdr_slot) shift_q <= shift_q >> 8;
              cnt_q <= cnt_q + 1'b1;
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_accept = accept_q;
  assign bus.req_done   = done_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.TX_DATA    = tx_data_q;
  assign bus.TX_WE      = tx_we_q;

endmodule
